uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the transmit-side counterpart to uart_rx.
- Accepts bytes through a valid/ready write port into an internal FIFO, then serialises them on tx.
- Frame format: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Paced by the shared 16x-oversample baud_tick from baud_gen, so frames are sampled correctly by uart_rx in loopback.

Parameters:
- DATA_BITS, 8: data bits per frame (5..8).
- FIFO_DEPTH, 16: FIFO entries; power of 2, >= 2.
- SAMPLE_RATE, 16: baud_tick pulses per bit period.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk pulse at SAMPLE_RATE x baud rate.
- wr_valid  input  1  write request.
- wr_data  input  DATA_BITS  byte to queue.
- wr_ready  output  1  FIFO can accept a write this cycle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-clk pulse at end of each frame's last stop bit.

Behaviour:

Reset:
- Values: tx = 1, tx_busy = 0, tx_done = 0, fifo_count = 0, state = IDLE, FIFO pointers = 0.
- Reset mid-frame aborts the frame: tx = 1 on the clock after rst is sampled high, and all queued data is discarded.
- Writes are ignored while rst is high.

FIFO:
- wr_ready = (fifo_count != FIFO_DEPTH), combinational from the registered count.
- A write occurs when wr_valid && wr_ready.
- A pop occurs when the FSM leaves IDLE.
- Simultaneous write and pop: both take effect and the count is unchanged.
- Write while full is dropped (wr_ready = 0).
- Pointers wrap modulo FIFO_DEPTH.
- No fall-through: a byte written into an empty FIFO in cycle N is popped in cycle N+1.

FSM states: IDLE, START, DATA, PARITY, STOP.

Bit timing:
- tick_cnt counts baud_tick pulses, 0..SAMPLE_RATE-1.
- A bit ends on the clk where baud_tick = 1 and tick_cnt = SAMPLE_RATE-1.
- tick_cnt clears on entry to START.

Transitions and tx values:
- IDLE: when fifo_count != 0, pop the head into the shift register and go to START. tx = 0 from the next clock (registered). tx_busy = 1 from the same clock.
- START: tx = 0 for one bit period, then go to DATA with bit_idx = 0.
- DATA: tx = shift[0], shifting right at each bit end. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else to STOP.
- PARITY: tx = ^data XOR PARITY_ODD, computed from the popped byte. Lasts one bit period, then go to STOP.
- STOP: tx = 1 for STOP_BITS bit periods. At the final bit end, pulse tx_done for 1 clk and return to IDLE.
- Back-to-back frames: if the FIFO is non-empty on return to IDLE, the next pop occurs on the following clk. The gap from end of stop bit to start bit is 1 clk; tx_busy stays 0 for that 1 clk.

Other rules:
- Bits above DATA_BITS in the shift register are don't-care.
- wr_data is captured at write time; later changes on wr_data do not affect queued bytes.

Test Plan:
- Single frame: baud_tick every 4 clks (bit = 64 clks), write 0xA5 -> tx shows 0, then 1,0,1,0,0,1,0,1, then 1; frame = 640 clks; one tx_done pulse; tx_busy falls with tx_done.
- Loopback to uart_rx: queue 0xA5, 0x3C, 0x00, 0xFF back-to-back -> uart_rx rx_data matches each byte in order; 4 tx_done pulses; stop-to-start gap of 1 clk.
- FIFO full: hold wr_valid for 18 consecutive bytes starting from idle -> 17 bytes accepted (first one popped); wr_ready = 0 and fifo_count = 16 at the 18th; the 18th byte is not transmitted until ready returns.
- Parity: PARITY_EN = 1 with data 0x07 -> parity bit 1 for PARITY_ODD = 0 and 0 for PARITY_ODD = 1; frame = 11 bits. STOP_BITS = 2 -> stop high for 128 clks.
- Reset mid-frame: assert rst during DATA bit 3 of 0x55 with 3 bytes queued -> next clk tx = 1, tx_busy = 0, fifo_count = 0; no tx_done; no further frames after rst deasserts.
- Simultaneous write and pop: write in the same clk the FSM pops -> fifo_count unchanged, both bytes transmitted in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a FIFO, serialised
// as start, LSB-first data, optional parity and 1-2 stop bits, paced by baud_tick.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SAMPLE_RATE = 16,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic [2:0]           r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic [2:0]           w_state_nxt;
  logic [TW-1:0]        w_tick_nxt;
  logic [BW-1:0]        w_bit_nxt;
  logic                 w_stop_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_nxt;
  logic                 w_tx_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  logic                 w_wr;
  logic                 w_pop;
  logic                 w_bit_end;

  assign wr_ready   = (r_count != CW'(FIFO_DEPTH));
  assign fifo_count = r_count;
  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

  assign w_wr      = wr_valid && wr_ready && !rst;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_bit_end = baud_tick && (r_tick == TW'(SAMPLE_RATE - 1));

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; tx is computed one clock ahead so the line is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (baud_tick) begin
      w_tick_nxt = w_bit_end ? '0 : r_tick + TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_par_nxt   = (^r_mem[r_rd_ptr]) ^ 1'(PARITY_ODD);
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == BW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_stop_nxt  = 1'b0;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit + BW'(1);
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop == 1'(STOP_BITS - 1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_stop_nxt = r_stop + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (plain 8N1, even parity,
// odd parity with 2 stop bits) decoded by a bit-centre sampling receiver.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick;
  logic [1:0] bcnt = 2'd0;
  logic       wr_v = 1'b0;
  logic [7:0] wr_d = 8'h00;
  logic [1:0] sel = 2'd0;

  logic [2:0] wv_w;
  logic [2:0] rdy_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [4:0] cnt_w [3];

  logic       tx_sel, busy_sel, done_sel, rdy_sel;
  logic [4:0] cnt_sel;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int rise_cyc [3];
  int done_cyc [3];
  int done_cnt [3];
  logic [2:0] busy_q = 3'b000;

  always #5 clk = ~clk;

  // 16x tick every 4 clocks, so one bit lasts 64 clocks
  always @(posedge clk) bcnt <= bcnt + 2'd1;
  assign baud_tick = (bcnt == 2'd3);

  assign wv_w[0] = wr_v && (sel == 2'd0);
  assign wv_w[1] = wr_v && (sel == 2'd1);
  assign wv_w[2] = wr_v && (sel == 2'd2);

  assign tx_sel   = tx_w[sel];
  assign busy_sel = busy_w[sel];
  assign done_sel = done_w[sel];
  assign rdy_sel  = rdy_w[sel];
  assign cnt_sel  = cnt_w[sel];

  uart_tx_fifo #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_valid(wv_w[0]), .wr_data(wr_d),
    .wr_ready(rdy_w[0]), .fifo_count(cnt_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .tx_done(done_w[0]));

  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_valid(wv_w[1]), .wr_data(wr_d),
    .wr_ready(rdy_w[1]), .fifo_count(cnt_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .tx_done(done_w[1]));

  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_valid(wv_w[2]), .wr_data(wr_d),
    .wr_ready(rdy_w[2]), .fifo_count(cnt_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
    .tx_done(done_w[2]));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k] && !busy_q[k]) rise_cyc[k] <= cyc;
      if (done_w[k]) begin
        done_cyc[k] <= cyc;
        done_cnt[k] <= done_cnt[k] + 1;
      end
    end
    busy_q <= busy_w;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    while (!rdy_sel && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", int'(rdy_sel), 1);
    wr_v = 1'b1;
    wr_d = 8'(v);
    @(negedge clk);
    wr_v = 1'b0;
  endtask

  // Sample each bit at its centre, then follow the stop period to tx_done.
  task automatic recv(input int exp_byte, input bit par_en, input int exp_par,
                      input bit exp_next, output int stop_len);
    int n, b, bad, t0;
    n = 0;
    while (tx_sel !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", int'(tx_sel), 0);
    repeat (32) @(negedge clk);
    check("start_bit", int'(tx_sel), 0);
    b = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge clk);
      b[i] = tx_sel;
    end
    check("data", b, exp_byte);
    if (par_en) begin
      repeat (64) @(negedge clk);
      check("parity", int'(tx_sel), exp_par);
    end
    n = 0;
    while (tx_sel !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    bad = 0;
    n = 0;
    while (!done_sel && n < 300) begin
      @(negedge clk);
      if (tx_sel !== 1'b1) bad++;
      n++;
    end
    stop_len = cyc - t0;
    check("stop_high", bad, 0);
    check("done_seen", int'(done_sel), 1);
    check("busy_with_done", int'(busy_sel), 0);
    @(negedge clk);
    check("done_pulse", int'(done_sel), 0);
    if (exp_next) begin
      check("gap_busy", int'(busy_sel), 1);
      check("gap_tx", int'(tx_sel), 0);
    end
  endtask

  task automatic fill_full();
    int acc, n;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      wr_v = 1'b1;
      wr_d = 8'(8'h40 + i);
      if (rdy_sel) acc++;
      @(negedge clk);
    end
    check("full_accepted", acc, 17);
    wr_d = 8'h51;
    check("full_ready", int'(rdy_sel), 0);
    check("full_count", int'(cnt_sel), 16);
    n = 0;
    while (!rdy_sel && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_return", int'(rdy_sel), 1);
    @(negedge clk);
    wr_v = 1'b0;
    check("refill_count", int'(cnt_sel), 16);
  endtask

  task automatic recv_full();
    int sl;
    for (int i = 0; i < 18; i++) begin
      recv(8'h40 + i, 1'b0, 0, (i < 17), sl);
    end
  endtask

  initial begin
    int sl, d0, zeros;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx_w[0]), 1);
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);
    check("rst_count", int'(cnt_w[0]), 0);
    check("rst_ready", int'(rdy_w[0]), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 8N1 frame
    sel = 2'd0;
    d0 = done_cnt[0];
    send(8'hA5);
    recv(8'hA5, 1'b0, 0, 1'b0, sl);
    check("single_done_cnt", done_cnt[0] - d0, 1);
    sl = done_cyc[0] - rise_cyc[0];
    check("single_frame_len", int'(sl >= 637 && sl <= 640), 1);

    // back-to-back frames
    d0 = done_cnt[0];
    send(8'hA5);
    send(8'h3C);
    send(8'h00);
    send(8'hFF);
    recv(8'hA5, 1'b0, 0, 1'b1, sl);
    recv(8'h3C, 1'b0, 0, 1'b1, sl);
    recv(8'h00, 1'b0, 0, 1'b1, sl);
    recv(8'hFF, 1'b0, 0, 1'b0, sl);
    check("b2b_done_cnt", done_cnt[0] - d0, 4);

    // write coinciding with the pop
    repeat (5) @(negedge clk);
    send(8'h81);
    check("simul_count_a", int'(cnt_sel), 1);
    send(8'h7E);
    check("simul_count_b", int'(cnt_sel), 1);
    check("simul_busy", int'(busy_sel), 1);
    recv(8'h81, 1'b0, 0, 1'b1, sl);
    recv(8'h7E, 1'b0, 0, 1'b0, sl);

    // FIFO full while first byte transmits
    repeat (5) @(negedge clk);
    fork
      fill_full();
      recv_full();
    join
    check("full_drain_count", int'(cnt_sel), 0);

    // even parity, 11-bit frame
    sel = 2'd1;
    repeat (3) @(negedge clk);
    send(8'h07);
    recv(8'h07, 1'b1, 1, 1'b0, sl);
    sl = done_cyc[1] - rise_cyc[1];
    check("par_even_len", int'(sl >= 701 && sl <= 704), 1);

    // odd parity, two stop bits
    sel = 2'd2;
    repeat (3) @(negedge clk);
    send(8'h07);
    recv(8'h07, 1'b1, 0, 1'b0, sl);
    check("stop2_len", sl, 128);
    sl = done_cyc[2] - rise_cyc[2];
    check("par_odd_len", int'(sl >= 765 && sl <= 768), 1);

    // reset in the middle of DATA bit 3 with three bytes queued
    sel = 2'd0;
    repeat (3) @(negedge clk);
    send(8'h55);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check("rst_queued", int'(cnt_sel), 3);
    repeat (32 + 64 * 4 - 3) @(negedge clk);
    check("rst_bit3", int'(tx_sel), 0);
    check("rst_mid_busy", int'(busy_sel), 1);
    d0 = done_cnt[0];
    rst = 1'b1;
    wr_v = 1'b1;
    wr_d = 8'h99;
    @(negedge clk);
    rst = 1'b0;
    wr_v = 1'b0;
    check("abort_tx", int'(tx_sel), 1);
    check("abort_busy", int'(busy_sel), 0);
    check("abort_count", int'(cnt_sel), 0);
    zeros = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (tx_sel !== 1'b1) zeros++;
    end
    check("abort_line_idle", zeros, 0);
    check("abort_no_done", done_cnt[0] - d0, 0);
    check("abort_count_after", int'(cnt_sel), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
